// File: rtl/aes128_req_scheduler_pkg.sv
// aes128_req_scheduler_pkg: shared types and constants for the AES-128 request scheduler
package aes128_req_scheduler_pkg;
    localparam int NR_128 = 10;
    localparam int AES_W  = 128;
    typedef enum logic [1:0] {OP_NOP = 2'd0, OP_INIT = 2'd1, OP_MID = 2'd2, OP_FINAL = 2'd3} aes_op_e;
    typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, ROUND = 2'd2, DONE = 2'd3} sched_state_e;
endpackage

// File: rtl/aes128_req_scheduler_arb.sv
// aes_rr_arbiter: picks the first requester after the pointer, wrapping, as one-hot and index
module aes_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);
    logic [IDW-1:0] j;
    // Scan farthest-to-nearest so the nearest valid requester after the pointer wins
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = '0;
        for (int i = NREQ; i >= 1; i--) begin
            j = IDW'((int'(ptr_i) + i) % NREQ);
            if (req_i[j]) begin
                gnt_o   = NREQ'(1) << j;
                idx_o   = j;
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/aes128_req_scheduler.sv
// aes128_req_scheduler: round-robin sharing of one iterative AES-128 round datapath
module aes128_req_scheduler
    import aes128_req_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NR   = NR_128,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][AES_W-1:0]  req_text,
    input  logic [NREQ-1:0][AES_W-1:0]  req_key,
    output logic [1:0]                  dp_op,
    output logic [3:0]                  dp_rnd,
    output logic [AES_W-1:0]            dp_state,
    output logic [AES_W-1:0]            dp_key,
    input  logic [AES_W-1:0]            dp_state_nxt,
    input  logic [AES_W-1:0]            dp_key_nxt,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [AES_W-1:0]            rsp_text,
    output logic                        busy
);
    sched_state_e     state_q;
    aes_op_e          op_q;
    logic [AES_W-1:0] st_q, key_q;
    logic [3:0]       rnd_q;
    logic [IDW-1:0]   id_q, ptr_q;
    logic             rsp_valid_q, busy_q;
    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             arb_valid;

    aes_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign req_ready = (state_q == IDLE && rst_n) ? arb_gnt : '0;
    assign dp_op     = op_q;
    assign dp_rnd    = rnd_q;
    assign dp_state  = st_q;
    assign dp_key    = key_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_text  = st_q;
    assign busy      = busy_q;

    // Scheduler FSM: grant, INIT round, NR rounds, then hold the response until accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            st_q        <= '0;
            key_q       <= '0;
            rnd_q       <= '0;
            id_q        <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (arb_valid) begin
                    st_q    <= req_text[arb_idx];
                    key_q   <= req_key[arb_idx];
                    id_q    <= arb_idx;
                    ptr_q   <= arb_idx;
                    op_q    <= OP_INIT;
                    busy_q  <= 1'b1;
                    state_q <= INIT;
                end
                INIT: begin
                    st_q    <= dp_state_nxt;
                    key_q   <= dp_key_nxt;
                    rnd_q   <= 4'd1;
                    op_q    <= (NR == 1) ? OP_FINAL : OP_MID;
                    state_q <= ROUND;
                end
                ROUND: begin
                    st_q  <= dp_state_nxt;
                    key_q <= dp_key_nxt;
                    if (rnd_q == 4'(NR)) begin
                        rnd_q       <= '0;
                        op_q        <= OP_NOP;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                        op_q  <= (rnd_q + 4'd1 == 4'(NR)) ? OP_FINAL : OP_MID;
                    end
                end
                DONE: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_req_scheduler.sv
// tb_aes128_req_scheduler: randomized and directed checks of the scheduler against an AES reference
module tb_aes128_req_scheduler;
    import aes128_req_scheduler_pkg::*;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0][127:0] req_text = '0;
    logic [NREQ-1:0][127:0] req_key = '0;
    logic [1:0] dp_op;
    logic [3:0] dp_rnd;
    logic [127:0] dp_state, dp_key, dp_state_nxt, dp_key_nxt;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [IDW-1:0] rsp_id;
    logic [127:0] rsp_text;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    aes128_req_scheduler #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_text(req_text), .req_key(req_key),
        .dp_op(dp_op), .dp_rnd(dp_rnd), .dp_state(dp_state), .dp_key(dp_key),
        .dp_state_nxt(dp_state_nxt), .dp_key_nxt(dp_key_nxt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_text(rsp_text),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // AES-128 arithmetic helpers; byte 0 is bits [127:120], state is column-major
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= a;
            a = xt(a);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p = 8'h01;
        logic [7:0] b;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) p = gmul(p, x);
        b = p;
        s = p;
        for (int k = 0; k < 4; k++) begin
            b = {b[6:0], b[7]};
            s ^= b;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        int src;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] mixcol(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[103-32*c -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input int i);
        logic [7:0] r = 8'h01;
        for (int j = 1; j < i; j++) r = xt(r);
        return r;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s = p ^ k;
        for (int r = 1; r <= 10; r++) begin
            k = key_exp(k, rcon(r));
            s = sub_shift(s);
            if (r < 10) s = mixcol(s);
            s ^= k;
        end
        return s;
    endfunction

    // Reference round/key-expansion datapath attached to the scheduler
    always_comb begin
        dp_key_nxt   = key_exp(dp_key, rcon(int'(dp_rnd) + 1));
        dp_state_nxt = (dp_op == OP_INIT)  ? dp_state ^ dp_key :
                       (dp_op == OP_MID)   ? mixcol(sub_shift(dp_state)) ^ dp_key :
                       (dp_op == OP_FINAL) ? sub_shift(dp_state) ^ dp_key : 128'h0;
    end

    // Transaction-level model: idle/busy with a cycle count since accept
    bit mon_en = 1'b0;
    bit m_busy = 1'b0;
    bit m_zero = 1'b1;
    int m_k = 0;
    int m_ptr = NREQ - 1;
    int m_id = 0;
    logic [127:0] m_exp = '0;
    logic [NREQ-1:0] last_gnt = '0;
    logic [NREQ-1:0] e_rdy;
    int g, e_op, e_rnd, n_rsp = 0;
    int dut_grants[$];

    // Compare every output once per cycle, then advance the model with the same inputs the DUT sees
    always @(negedge clk) begin
        if (mon_en) begin
            e_rdy = '0;
            g = -1;
            if (rst_n && !m_busy)
                for (int i = 1; i <= NREQ; i++)
                    if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
            if (g >= 0) e_rdy[g] = 1'b1;
            e_op  = (!m_busy || m_k >= 12) ? 0 : (m_k == 1) ? 1 : (m_k <= 10) ? 2 : 3;
            e_rnd = (m_busy && m_k < 12) ? m_k - 1 : 0;
            check("req_ready", 128'(req_ready), 128'(e_rdy));
            check("dp_op", 128'(dp_op), 128'(e_op));
            check("dp_rnd", 128'(dp_rnd), 128'(e_rnd));
            check("busy", 128'(busy), 128'(m_busy));
            check("rsp_valid", 128'(rsp_valid), 128'(m_busy && m_k >= 12));
            if (m_busy && m_k >= 12) begin
                check("rsp_id", 128'(rsp_id), 128'(m_id));
                check("rsp_text", rsp_text, m_exp);
            end
            if (m_zero) begin
                check("dp_state_rst", dp_state, 128'h0);
                check("dp_key_rst", dp_key, 128'h0);
                check("rsp_id_rst", 128'(rsp_id), 128'h0);
            end
            if (|req_ready) dut_grants.push_back($clog2(req_ready));
            last_gnt = req_ready;
            if (!rst_n) begin
                m_busy = 1'b0;
                m_zero = 1'b1;
                m_ptr  = NREQ - 1;
                m_k    = 0;
            end else if (g >= 0) begin
                m_busy = 1'b1;
                m_zero = 1'b0;
                m_k    = 1;
                m_ptr  = g;
                m_id   = g;
                m_exp  = aes_encrypt(req_text[g], req_key[g]);
            end else if (m_busy && m_k < 12) begin
                m_k++;
            end else if (m_busy && rsp_ready) begin
                m_busy = 1'b0;
                n_rsp++;
            end
        end
    end

    task automatic wait_for(input int sel, input int lim, output int cyc);
        bit hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < lim) begin
            @(negedge clk);
            #1;
            cyc++;
            hit = (sel == 0) ? |req_ready : (sel == 1) ? rsp_valid : (sel == 2) ? (dp_rnd == 4'd4) : !busy;
        end
        if (!hit) check($sformatf("timeout_sel%0d", sel), 128'h0, 128'h1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int c, rsp_before;
    logic [127:0] t_hold;
    logic [IDW-1:0] id_hold;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known-answer vector on requester 0, with exact latency
        req_text[0] = 128'h3243f6a8885a308d313198a2e0370734;
        req_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        req_valid   = 4'b0001;
        wait_for(0, 20, c);
        check("t1_ready", 128'(req_ready), 128'h1);
        @(posedge clk);
        #1 req_valid = '0;
        wait_for(1, 40, c);
        check("t1_latency", 128'(c), 128'd12);
        check("t1_text", rsp_text, 128'h3925841d02dc09fbdc118597196a0b32);
        check("t1_id", 128'(rsp_id), 128'h0);

        // Known-answer vector on requester 2
        @(posedge clk);
        #1 req_text[2] = 128'h00112233445566778899aabbccddeeff;
        req_key[2] = 128'h000102030405060708090a0b0c0d0e0f;
        req_valid  = 4'b0100;
        wait_for(0, 20, c);
        @(posedge clk);
        #1 req_valid = '0;
        wait_for(1, 40, c);
        check("t2_text", rsp_text, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("t2_id", 128'(rsp_id), 128'h2);

        // All requesters held valid from reset: grant order 0,1,2,3,0
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_text[i] = rnd128();
            req_key[i]  = rnd128();
        end
        req_valid = '1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        dut_grants.delete();
        for (int i = 0; i < 100 && dut_grants.size() < 5; i++) begin
            @(negedge clk);
            #1;
        end
        check("t3_grant_count", 128'(dut_grants.size() >= 5), 128'h1);
        for (int i = 0; i < 5 && i < dut_grants.size(); i++)
            check($sformatf("t3_grant%0d", i), 128'(dut_grants[i]), 128'(exp_order[i]));
        @(posedge clk);
        #1 req_valid = '0;
        wait_for(3, 40, c);

        // Response stalled for 5 cycles while another requester waits
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        req_text[1] = rnd128();
        req_key[1]  = rnd128();
        req_valid   = 4'b0010;
        wait_for(0, 20, c);
        @(posedge clk);
        #1 req_valid = 4'b0100;
        wait_for(1, 40, c);
        t_hold  = rsp_text;
        id_hold = rsp_id;
        check("t4_id", 128'(rsp_id), 128'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("t4_hold_text", rsp_text, t_hold);
            check("t4_hold_id", 128'(rsp_id), 128'(id_hold));
            check("t4_hold_valid", 128'(rsp_valid), 128'h1);
            check("t4_no_grant", 128'(req_ready), 128'h0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        #1 check("t4_valid_at_accept", 128'(rsp_valid), 128'h1);
        @(negedge clk);
        #1 check("t4_idle_busy", 128'(busy), 128'h0);
        check("t4_idle_valid", 128'(rsp_valid), 128'h0);
        check("t4_next_grant", 128'(req_ready), 128'h4);
        @(posedge clk);
        #1 req_valid = '0;
        wait_for(3, 40, c);

        // Reset in the middle of a block, then pointer back at NREQ-1
        @(posedge clk);
        #1 req_valid = 4'b0001;
        wait_for(0, 20, c);
        @(posedge clk);
        #1 req_valid = '0;
        wait_for(2, 20, c);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 check("t6_rnd_at_reset", 128'(dp_rnd), 128'h5);
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = 4'b0011;
        dut_grants.delete();
        @(negedge clk);
        #1 check("t6_busy", 128'(busy), 128'h0);
        check("t6_op", 128'(dp_op), 128'h0);
        check("t6_valid", 128'(rsp_valid), 128'h0);
        check("t6_state", dp_state, 128'h0);
        check("t6_grant0", 128'(req_ready), 128'h1);
        @(posedge clk);
        #1 req_valid = 4'b0010;
        wait_for(0, 40, c);
        check("t6_grant1", 128'(req_ready), 128'h2);
        @(posedge clk);
        #1 req_valid = '0;
        wait_for(3, 40, c);

        // Random traffic with random response back-pressure
        rsp_before = n_rsp;
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (last_gnt[i]) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_text[i]  = rnd128();
                    req_key[i]   = rnd128();
                end else if (req_valid[i] && $urandom_range(49) == 0) req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(2) != 0);
        end
        @(posedge clk);
        #1 req_valid = '0;
        rsp_ready = 1'b1;
        wait_for(3, 40, c);
        check("rand_responses", 128'(n_rsp - rsp_before > 20), 128'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
